player_input_capture: RTL and testbench

Front-end for the player buttons of the Genius game: synchronizes and debounces the raw push-button vector, detects a single new press, and delivers it to the game controller as a one-cycle `button_player_pressed` strobe with the pressed pattern held on `player_input`. The output encoding is one-hot, bit i for button i, identical to the `sequence_item` encoding, so the controller compares the two vectors directly. The block sits between the board button pins and the controller. Capture is gated by the controller's `player_wr` strobe.

---
 rtl/player_input_capture.sv | 113 +++++++++++
 tb/tb_player_input_capture.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/player_input_capture.sv
// Button front-end for the Genius game: synchronize, debounce, and turn each
// new single-button press into a one-cycle strobe with a held one-hot pattern.
//
// state        | meaning
// RELEASE_WAIT | after reset, wait for the debounced vector to read all-released
// ARMED        | all released; the next non-zero debounced vector is a new press
// HELD         | press already handled; ignore changes until full release
module player_input_capture #(
  parameter  int DATA_WIDTH      = 4,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buttons_raw,
  input  logic                  player_wr,
  output logic [DATA_WIDTH-1:0] player_input,
  output logic                  button_player_pressed,
  output logic                  multi_press_error,
  output logic [DATA_WIDTH-1:0] buttons_debounced
);

  localparam logic [1:0] RELEASE_WAIT = 2'd0;
  localparam logic [1:0] ARMED        = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] sync1_q, sync1_d;
  logic [DATA_WIDTH-1:0] sync2_q, sync2_d;
  logic [DATA_WIDTH-1:0] cand_q, cand_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] deb_q, deb_d;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pin_q, pin_d;
  logic                  pressed_q, pressed_d;
  logic                  err_q, err_d;
  logic                  one_hot;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign one_hot = (deb_q & (deb_q - DATA_WIDTH'(1))) == '0;

  always_comb begin
    sync1_d = buttons_raw;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    pin_d     = pin_q;
    pressed_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      RELEASE_WAIT: if (deb_q == '0) state_d = ARMED;
      ARMED: begin
        if (deb_q != '0) begin
          state_d = HELD;
          if (player_wr) begin
            if (one_hot) begin
              pin_d     = deb_q;
              pressed_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      HELD:    if (deb_q == '0) state_d = ARMED;
      default: state_d = RELEASE_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      deb_q     <= '0;
      state_q   <= RELEASE_WAIT;
      pin_q     <= '0;
      pressed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      state_q   <= state_d;
      pin_q     <= pin_d;
      pressed_q <= pressed_d;
      err_q     <= err_d;
    end
  end

  assign player_input          = pin_q;
  assign button_player_pressed = pressed_q;
  assign multi_press_error     = err_q;
  assign buttons_debounced     = deb_q;

endmodule

// File: tb/tb_player_input_capture.sv
// Bench for player_input_capture: directed scenarios plus random presses,
// checked cycle by cycle against a sample-history reference model.
module tb_player_input_capture;
  localparam int DW  = 4;
  localparam int DEB = 16;
  localparam int HL  = DEB + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] buttons_raw = '0;
  logic          player_wr = 1'b0;
  logic [DW-1:0] player_input;
  logic          button_player_pressed;
  logic          multi_press_error;
  logic [DW-1:0] buttons_debounced;

  player_input_capture #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .buttons_raw          (buttons_raw),
    .player_wr            (player_wr),
    .player_input         (player_input),
    .button_player_pressed(button_player_pressed),
    .multi_press_error    (multi_press_error),
    .buttons_debounced    (buttons_debounced)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raw samples since reset, oldest first.
  logic [DW-1:0] hist[$];
  logic [DW-1:0] m_deb, m_pin;
  logic          m_pr, m_er, m_armed;

  // Scenario bookkeeping from observed outputs.
  int k;
  int n_pr, n_er, pr_at, deb_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic void model_edge(input logic [DW-1:0] r, input logic wr, input logic rs);
    bit stable;
    if (rs) begin
      hist.delete();
      for (int i = 0; i < HL; i++) hist.push_back('0);
      m_deb = '0; m_pin = '0; m_pr = 1'b0; m_er = 1'b0; m_armed = 1'b0;
      return;
    end
    m_pr = 1'b0;
    m_er = 1'b0;
    // A press is taken only from a fully released state, and only once.
    if (!m_armed) begin
      if (m_deb == '0) m_armed = 1'b1;
    end else if (m_deb != '0) begin
      m_armed = 1'b0;
      if (wr) begin
        if ($countones(m_deb) == 1) begin
          m_pin = m_deb;
          m_pr  = 1'b1;
        end else begin
          m_er = 1'b1;
        end
      end
    end
    hist.push_back(r);
    void'(hist.pop_front());
    // Debounced value follows a raw level held for DEB+1 samples, seen two edges late.
    stable = 1'b1;
    for (int i = 1; i <= DEB; i++) if (hist[i] != hist[0]) stable = 1'b0;
    if (stable) m_deb = hist[0];
  endfunction

  task automatic step(input logic [DW-1:0] r, input logic wr, input logic rs);
    @(negedge clk);
    buttons_raw = r;
    player_wr   = wr;
    rst         = rs;
    @(posedge clk);
    model_edge(r, wr, rs);
    #1;
    check("debounced", 32'(buttons_debounced), 32'(m_deb));
    check("player_input", 32'(player_input), 32'(m_pin));
    check("pressed", 32'(button_player_pressed), 32'(m_pr));
    check("multi_err", 32'(multi_press_error), 32'(m_er));
    if (button_player_pressed) begin n_pr++; pr_at = k; end
    if (multi_press_error) n_er++;
    if (int'(buttons_debounced) > deb_max) deb_max = int'(buttons_debounced);
    k++;
  endtask

  task automatic new_scn();
    k = 0; n_pr = 0; n_er = 0; pr_at = -1; deb_max = 0;
  endtask

  task automatic hold(input logic [DW-1:0] r, input logic wr, input int n);
    for (int i = 0; i < n; i++) step(r, wr, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] pat;
    int            len;
    logic          wr;
    new_scn();
    step('0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1);
    check("reset_pin", 32'(player_input), 32'h0);
    check("reset_deb", 32'(buttons_debounced), 32'h0);
    check("reset_pulses", 32'(button_player_pressed | multi_press_error), 32'h0);

    // Clean press.
    new_scn();
    hold(4'b0100, 1'b1, 40);
    check("clean_count", 32'(n_pr), 32'd1);
    check("clean_edge", 32'(pr_at), 32'd19);
    check("clean_err", 32'(n_er), 32'd0);
    hold('0, 1'b1, 25);
    check("clean_pin_held", 32'(player_input), 32'h4);

    // Bounce, then stable.
    new_scn();
    for (int t = 0; t < 5; t++) begin
      hold(4'b0010, 1'b1, 3);
      hold(4'b0000, 1'b1, 3);
    end
    new_scn();
    hold(4'b0010, 1'b1, 40);
    check("bounce_count", 32'(n_pr), 32'd1);
    check("bounce_edge", 32'(pr_at), 32'd19);
    check("bounce_pin", 32'(player_input), 32'h2);
    hold('0, 1'b1, 25);

    // Chord rejected, then a single press accepted.
    new_scn();
    hold(4'b1001, 1'b1, 40);
    check("chord_err", 32'(n_er), 32'd1);
    check("chord_pr", 32'(n_pr), 32'd0);
    check("chord_pin", 32'(player_input), 32'h2);
    hold('0, 1'b1, 25);
    new_scn();
    hold(4'b0001, 1'b1, 40);
    check("single_count", 32'(n_pr), 32'd1);
    check("single_pin", 32'(player_input), 32'h1);
    hold('0, 1'b1, 25);

    // Held while disabled, enable raised mid-hold.
    new_scn();
    hold(4'b1000, 1'b0, 25);
    hold(4'b1000, 1'b1, 20);
    check("disabled_pr", 32'(n_pr + n_er), 32'd0);
    hold('0, 1'b1, 25);
    new_scn();
    hold(4'b0100, 1'b1, 40);
    check("enabled_count", 32'(n_pr), 32'd1);
    check("enabled_pin", 32'(player_input), 32'h4);
    hold('0, 1'b1, 25);

    // Short glitch.
    new_scn();
    hold(4'b0001, 1'b1, 10);
    hold('0, 1'b1, 30);
    check("glitch_deb", 32'(deb_max), 32'd0);
    check("glitch_pulses", 32'(n_pr + n_er), 32'd0);

    // Reset mid-debounce with the button kept down.
    new_scn();
    hold(4'b0001, 1'b1, 10);
    step(4'b0001, 1'b1, 1'b1);
    check("midrst_pin", 32'(player_input), 32'h0);
    check("midrst_deb", 32'(buttons_debounced), 32'h0);
    new_scn();
    hold(4'b0001, 1'b1, 40);
    check("midrst_edge", 32'(pr_at), 32'd19);
    check("midrst_count", 32'(n_pr), 32'd1);
    hold('0, 1'b1, 25);

    // Random presses, chords, glitches, enable changes and rare resets.
    for (int seg = 0; seg < 120; seg++) begin
      case ($urandom_range(0, 3))
        0:       pat = '0;
        1:       pat = DW'(1) << $urandom_range(0, DW - 1);
        2:       pat = DW'($urandom_range(0, (1 << DW) - 1));
        default: pat = DW'(1) << $urandom_range(0, DW - 1);
      endcase
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : $urandom_range(18, 45);
      wr  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++)
        step(pat, wr, ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
